// File: rtl/game_fsm.sv
// game_fsm: match controller for a two-player ball game.
// Detects goals from the ball X position, keeps score, paces serves.
module game_fsm #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 60,
  parameter int GOAL_MARGIN = 8,
  parameter int HOR_PIXELS  = 1024,
  parameter int BALL_SIZE   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic [10:0] x_ball,
  output logic [1:0]  state,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        winner,
  output logic        point_pulse
);

  typedef enum logic [1:0] {
    START = 2'b00,
    PLAY  = 2'b01,
    POINT = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam int RIGHT_TH =
    HOR_PIXELS - BALL_SIZE - GOAL_MARGIN;

  state_t      state_q;
  logic [3:0]  sl_q, sr_q;
  logic        win_q, pulse_q;
  logic        start_q;
  logic [7:0]  serve_q;

  logic signed [31:0] x_w;
  logic        left_goal, right_goal;
  logic        start_rise;
  logic [7:0]  serve_d;
  logic [3:0]  sl_d, sr_d;

  // 32-bit signed compare so no threshold can wrap
  assign x_w        = $signed({21'b0, x_ball});
  assign left_goal  = x_w <= GOAL_MARGIN;
  assign right_goal = x_w >= RIGHT_TH;
  assign start_rise = start & ~start_q;
  assign serve_d    = serve_q + 8'd1;
  assign sl_d       = (sl_q == 4'hF) ? sl_q : sl_q + 4'd1;
  assign sr_d       = (sr_q == 4'hF) ? sr_q : sr_q + 4'd1;

  // Match FSM with all outputs held in registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START;
      sl_q    <= 4'd0;
      sr_q    <= 4'd0;
      win_q   <= 1'b0;
      pulse_q <= 1'b0;
      start_q <= 1'b0;
      serve_q <= 8'd0;
    end else begin
      start_q <= start;
      pulse_q <= 1'b0;
      unique case (state_q)
        START: begin
          if (start_rise) begin
            state_q <= PLAY;
            sl_q    <= 4'd0;
            sr_q    <= 4'd0;
          end
        end
        PLAY: begin
          if (timing_tick && left_goal) begin
            sr_q    <= sr_d;
            pulse_q <= 1'b1;
            serve_q <= 8'd0;
            if (sr_d == 4'(WIN_SCORE)) begin
              state_q <= OVER;
              win_q   <= 1'b1;
            end else begin
              state_q <= POINT;
            end
          end else if (timing_tick && right_goal) begin
            sl_q    <= sl_d;
            pulse_q <= 1'b1;
            serve_q <= 8'd0;
            if (sl_d == 4'(WIN_SCORE)) begin
              state_q <= OVER;
              win_q   <= 1'b0;
            end else begin
              state_q <= POINT;
            end
          end
        end
        POINT: begin
          if (timing_tick) begin
            serve_q <= serve_d;
            if (serve_d == 8'(SERVE_TICKS))
              state_q <= PLAY;
          end
        end
        OVER: begin
          if (start_rise)
            state_q <= START;
        end
        default: state_q <= START;
      endcase
    end
  end

  assign state       = state_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;
  assign winner      = win_q;
  assign point_pulse = pulse_q;

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed vector bench for game_fsm.
// Expected outputs are queued at drive time and popped after the edge.
module tb_game_fsm;

  logic        clk = 1'b0;
  logic        rst, timing_tick, start;
  logic [10:0] x_ball;
  logic [1:0]  state;
  logic [3:0]  score_left, score_right;
  logic        winner, point_pulse;

  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_PLAY  = 2'b01;
  localparam logic [1:0] S_POINT = 2'b10;
  localparam logic [1:0] S_OVER  = 2'b11;

  game_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .timing_tick(timing_tick),
    .start      (start),
    .x_ball     (x_ball),
    .state      (state),
    .score_left (score_left),
    .score_right(score_right),
    .winner     (winner),
    .point_pulse(point_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rs;
    bit          tk;
    bit          st;
    logic [10:0] x;
    logic [1:0]  es;
    logic [3:0]  esl;
    logic [3:0]  esr;
    bit          ew;
    bit          ep;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[8];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic step(input string nm, input vec_t v);
    vec_t e;
    bit   ok;
    rst         = v.rs;
    timing_tick = v.tk;
    start       = v.st;
    x_ball      = v.x;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    ok = (state == e.es) && (score_left == e.esl) &&
         (score_right == e.esr) &&
         (point_pulse == e.ep) &&
         ((e.es != S_OVER) || (winner == e.ew));
    n_chk++;
    if (ok) n_pass++;
    else
      $display("FAIL %s: got st=%0d sl=%0d sr=%0d w=%0d p=%0d want st=%0d sl=%0d sr=%0d w=%0d p=%0d",
               nm, state, score_left, score_right, winner,
               point_pulse, e.es, e.esl, e.esr, e.ew, e.ep);
  endtask

  task automatic go(input string nm, input bit rs, input bit tk,
                    input bit st, input int x, input logic [1:0] es,
                    input int sl, input int sr, input bit w,
                    input bit p);
    vec_t v;
    v = '{rs, tk, st, 11'(x), es, 4'(sl), 4'(sr), w, p};
    step(nm, v);
  endtask

  task automatic chk_serve(input string nm, input int exp);
    n_chk++;
    if (dut.serve_q == 8'(exp)) n_pass++;
    else
      $display("FAIL %s: got serve=%0d want %0d",
               nm, dut.serve_q, exp);
  endtask

  // Hold serve with tick high; rises on start must be ignored
  task automatic serve(input string nm, input int sl, input int sr,
                       input int first, input int x);
    for (int i = first; i <= 60; i++)
      go(nm, 0, 1, i[0], x, (i < 60) ? S_POINT : S_PLAY,
         sl, sr, 0, 0);
    go(nm, 0, 0, 0, 500, S_PLAY, sl, sr, 0, 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 1, 11'd500,  S_PLAY,  4'd0, 4'd0, 0, 0};
    tbl[1] = '{0, 0, 1, 11'd500,  S_PLAY,  4'd0, 4'd0, 0, 0};
    tbl[2] = '{0, 1, 0, 11'd9,    S_PLAY,  4'd0, 4'd0, 0, 0};
    tbl[3] = '{0, 1, 1, 11'd999,  S_PLAY,  4'd0, 4'd0, 0, 0};
    tbl[4] = '{0, 0, 0, 11'd5,    S_PLAY,  4'd0, 4'd0, 0, 0};
    tbl[5] = '{0, 0, 0, 11'd1000, S_PLAY,  4'd0, 4'd0, 0, 0};
    tbl[6] = '{0, 1, 0, 11'd5,    S_POINT, 4'd0, 4'd1, 0, 1};
    tbl[7] = '{0, 0, 0, 11'd5,    S_POINT, 4'd0, 4'd1, 0, 0};

    rst = 1'b1; timing_tick = 1'b0; start = 1'b0; x_ball = '0;
    go("reset0", 1, 0, 0, 0, S_START, 0, 0, 0, 0);
    go("reset1", 1, 1, 1, 5, S_START, 0, 0, 0, 0);
    go("idle",   0, 1, 0, 5, S_START, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      step($sformatf("tbl%0d", i), tbl[i]);

    serve("serve_l", 0, 1, 1, 5);

    go("rgoal", 0, 1, 0, 1000, S_POINT, 1, 1, 0, 1);
    for (int i = 1; i <= 10; i++)
      go("hold1000", 0, 1, 0, 1000, S_POINT, 1, 1, 0, 0);
    serve("serve_r", 1, 1, 11, 1000);

    for (int k = 2; k <= 5; k++) begin
      go($sformatf("lwin%0d", k), 0, 1, 0, 1023,
         (k == 5) ? S_OVER : S_POINT, k, 1, 0, 1);
      if (k < 5) serve("serve_k", k, 1, 1, 500);
    end

    go("over_h", 0, 1, 0, 5,   S_OVER,  5, 1, 0, 0);
    go("over_h", 0, 1, 0, 5,   S_OVER,  5, 1, 0, 0);
    go("over_s", 0, 0, 1, 5,   S_START, 5, 1, 0, 0);
    go("start0", 0, 1, 0, 5,   S_START, 5, 1, 0, 0);
    go("restrt", 0, 0, 1, 500, S_PLAY,  0, 0, 0, 0);
    go("play",   0, 0, 0, 500, S_PLAY,  0, 0, 0, 0);

    go("g2", 0, 1, 0, 0, S_POINT, 0, 1, 0, 1);
    for (int i = 1; i <= 30; i++)
      go("pt30", 0, 1, 0, 500, S_POINT, 0, 1, 0, 0);
    chk_serve("serve30", 30);
    go("rst_pt", 1, 1, 0, 500, S_START, 0, 0, 0, 0);
    chk_serve("serve0", 0);

    go("st2",    0, 0, 1, 500, S_PLAY,  0, 0, 0, 0);
    go("rst_gl", 1, 1, 0, 5,   S_START, 0, 0, 0, 0);
    go("nopls",  0, 0, 0, 5,   S_START, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter WIN_SCORE, default 5: points needed to win the match (range 1..15).
REQ-002 Parameter SERVE_TICKS, default 60: timing_tick count held in POINT before the next serve (range 1..255).
REQ-003 Parameter GOAL_MARGIN, default 8: edge distance in pixels that counts as a goal.
REQ-004 Parameter HOR_PIXELS, default 1024: visible screen width in pixels.
REQ-005 Parameter BALL_SIZE, default 16: ball edge length in pixels.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 timing_tick  input  1  single-cycle frame-rate pulse, same pulse the ball logic uses.
REQ-009 start  input  1  start/restart button level, already synchronised to clk.
REQ-010 x_ball  input  11  ball left-edge X position from the ball controller.
REQ-011 state  output  2  game state: START=2'b00, PLAY=2'b01, POINT=2'b10, OVER=2'b11.
REQ-012 score_left  output  4  left-player score, unsigned.
REQ-013 score_right  output  4  right-player score, unsigned.
REQ-014 winner  output  1  0 = left player won, 1 = right player won; valid only in OVER.
REQ-015 point_pulse  output  1  one-cycle pulse in the cycle a goal is registered.

Function
REQ-016 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-017 Goal detection in PLAY SHALL sample x_ball only on cycles where timing_tick=1.
- left_goal: x_ball <= GOAL_MARGIN.
- right_goal: x_ball >= HOR_PIXELS-BALL_SIZE-GOAL_MARGIN.
- Both comparisons at least 11 bits wide, unsigned, with no wrap.
REQ-018 Start edge: start_rise = start AND NOT start_d, where start_d is start delayed by one cycle (reset value 0).
REQ-019 START: ignore x_ball; on start_rise, go to PLAY next cycle and set both scores to 0.
REQ-020 PLAY, left_goal on a tick: score_right increments by 1 and point_pulse=1 for one cycle.
REQ-021 PLAY, right_goal on a tick: score_left increments by 1 and point_pulse=1 for one cycle.
REQ-022 PLAY, both goals true in the same tick: left_goal SHALL take priority; exactly one point is awarded.
REQ-023 After a goal, if the new score equals WIN_SCORE, go to OVER and set winner (1 if right scored); otherwise go to POINT and clear the serve counter.
REQ-024 Goal detection SHALL award at most one point per PLAY entry; the state leaves PLAY in the same cycle the point is registered.
REQ-025 POINT: an 8-bit serve counter increments on each timing_tick; at the tick that brings it to SERVE_TICKS, go to PLAY next cycle.
REQ-026 POINT: goal detection SHALL be disabled and start SHALL be ignored.
REQ-027 OVER: scores and winner hold; on start_rise, go to START next cycle.
REQ-028 Scores SHALL saturate at 15 and never wrap (only reachable if WIN_SCORE is misconfigured).
REQ-029 point_pulse SHALL be 0 in every cycle except the goal-registration cycle.
REQ-030 A start_rise in PLAY SHALL have no effect.
REQ-031 timing_tick held high for several cycles SHALL count each high cycle as one tick.

Reset
REQ-032 With rst=1 at a clock edge, the following SHALL apply next cycle regardless of current state:
- state=START, both scores=0, winner=0, point_pulse=0.
- serve counter=0, start_d=0.
REQ-033 Reset mid-POINT or mid-OVER SHALL abandon the pause or result with no residual point_pulse.
REQ-034 Outputs are don't-care before the first reset; the bench SHALL assert rst for at least 2 cycles.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Reset, start high for one cycle: state START->PLAY one cycle after the rising edge, scores 0/0.
- PLAY, x_ball=5 with tick: score_right=1, point_pulse one cycle, state=POINT; after exactly 60 ticks, state=PLAY.
- PLAY, x_ball=1000 with tick: score_left=1, state=POINT; x_ball=1000 held for 10 more ticks in POINT gives no further points.
- Left player reaches 5 (WIN_SCORE): state=OVER, winner=0, scores frozen; start_rise gives START; next start_rise gives PLAY with 0/0.
- x_ball=9 or x_ball=999 with tick in PLAY: no goal, state stays PLAY.
- rst asserted in POINT with serve counter at 30: state=START, scores 0/0, counter 0.
